lcd_cmd_host: RTL and testbench
===============================

// Module: lcd_cmd_host
// PURPOSE
//  Host-side counterpart of the LCD controller command interface. Plays a preloaded command
//  script into the controller over the cmd/cmd_valid/busy handshake and waits for done.
//  Acts as the IRAM sink: captures every IRAM write, counts it and checksums it.
//  Sits between the testbench/system host and the LCD controller.
// PARAMETERS
//  DEPTH  16   script entries (command slots)
//  AW     4    script address width; 2**AW >= DEPTH
//  TMO    255  watchdog limit, cycles, for the controller's busy/done response
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  ld_en      in   1   script write strobe; accepted only in IDLE
//  ld_addr    in   AW  script write address
//  ld_cmd     in   4   script command (0=write-out, 1-4 shift, 5-7 max/min/avg, 8-11 rotate/mirror)
//  ld_len     in   AW+1 script length; latched on start
//  start      in   1   begin playback; accepted only in IDLE
//  cmd        out  4   command to controller
//  cmd_valid  out  1   command strobe, one cycle per command
//  busy       in   1   controller busy
//  done       in   1   controller finished write-out
//  IRAM_valid in   1   controller write strobe
//  IRAM_A     in   6   write address
//  IRAM_D     in   8   write data
//  rd_addr    in   6   captured-image read address (combinational read)
//  rd_data    out  8   captured pixel at rd_addr
//  wr_cnt     out  7   number of IRAM writes captured (0..64, saturates at 127)
//  chk        out  16  sum of captured IRAM_D, mod 2**16
//  host_done  out  1   playback complete (sticky until next start)
//  err        out  1   protocol/timeout/illegal-command error (sticky until next start)
// BEHAVIOUR
//  Reset (reset=0): cmd=0, cmd_valid=0, host_done=0, err=0, wr_cnt=0, chk=0, FSM=IDLE, ptr=0.
//   Script and capture memories are not reset.
//  FSM: IDLE -> WAIT_RDY -> ISSUE -> WAIT_ACK -> WAIT_IDLE -> (WAIT_RDY | WAIT_DONE | FINISH); ERROR.
//  IDLE: ld_en writes script[ld_addr]=ld_cmd. start: latch len=ld_len; clear ptr, wr_cnt, chk,
//   host_done and err. If len==0, go straight to FINISH; else go to WAIT_RDY.
//  WAIT_RDY: wait for busy==0 (this covers the controller's image-load phase after reset).
//   script[ptr]>11: set err, increment ptr, stay (the command is skipped).
//   Else register cmd=script[ptr] and cmd_valid=1, then go to ISSUE.
//  ISSUE: cmd_valid high for exactly this one cycle; cmd holds its value. Next state is WAIT_ACK.
//  WAIT_ACK: busy must be 1 this cycle, since the controller raises busy on the sampling edge.
//   If busy==0, set err and go to ERROR.
//  WAIT_IDLE: wait for busy==0, then ptr++.
//   Issued cmd was 0: go to WAIT_DONE; remaining script entries are ignored.
//   Else if ptr==len: FINISH. Else: WAIT_RDY.
//  WAIT_DONE: wait for done==1, then go to FINISH.
//  FINISH: host_done=1; hold until start. ERROR: host_done=1, err=1; hold until start.
//  Watchdog: an 8-bit counter clears on every state change and counts in WAIT_RDY, WAIT_IDLE
//   and WAIT_DONE. Reaching TMO sets err and moves to ERROR.
//  cmd_valid is never asserted while busy==1 was sampled in the same cycle.
//  IRAM capture runs in every state, independent of the FSM. On IRAM_valid:
//   mem[IRAM_A]=IRAM_D; chk+=IRAM_D (8-bit value zero-extended, wraps mod 2**16);
//   wr_cnt++ (saturating).
//   Writes in the same cycle as start are dropped, because start clears the counters.
//  Reset asserted mid-playback: immediate return to IDLE; any in-flight command is abandoned.
//  start outside IDLE/FINISH/ERROR is ignored. start in FINISH/ERROR restarts with the held script.
// TESTING
//  1) Script {0}, len=1; controller model with image pixel=index:
//     one cmd_valid pulse with cmd=0 -> 64 writes, wr_cnt=64, chk=2016, host_done=1, err=0.
//  2) Script {1,3,5,0}: cmd_valid pulses only when busy==0, each one cycle wide, in order 1,3,5,0;
//     rd_data at 27 reflects max of the 2x2 at (2,2).
//  3) busy held high for 300 cycles after start -> err=1, host_done=1, no cmd_valid ever.
//  4) Script {12,2} -> 12 is skipped with err=1, cmd 2 still issued, FINISH (no done wait).
//  5) Controller model that never raises busy after cmd_valid -> err=1 on the WAIT_ACK cycle.
//  6) reset pulsed low during WAIT_IDLE -> all outputs at reset values next cycle;
//     a new start replays the script from ptr=0.

Source files
------------

// File: rtl/lcd_cmd_host.sv
// Host side of the LCD controller command interface: plays a preloaded script over
// cmd/cmd_valid/busy and captures, counts and checksums every IRAM write it sees.
module lcd_cmd_host #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int TMO   = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [3:0]    i_ld_cmd,
  input  logic [AW:0]   i_ld_len,
  input  logic          i_start,
  output logic [3:0]    o_cmd,
  output logic          o_cmd_valid,
  input  logic          i_busy,
  input  logic          i_done,
  input  logic          i_iram_valid,
  input  logic [5:0]    i_iram_a,
  input  logic [7:0]    i_iram_d,
  input  logic [5:0]    i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [6:0]    o_wr_cnt,
  output logic [15:0]   o_chk,
  output logic          o_host_done,
  output logic          o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ISSUE, S_WAIT_ACK, S_WAIT_IDLE, S_WAIT_DONE, S_FINISH, S_ERROR
  } state_t;

  localparam logic [7:0] TMO_L   = 8'(TMO);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [3:0]  r_script [DEPTH];
  logic [7:0]  r_mem [64];
  state_t      r_state;
  logic [AW:0] r_ptr;
  logic [AW:0] r_len;
  logic [7:0]  r_wdog;
  logic [3:0]  r_cmd;
  logic        r_cmd_valid;
  logic        r_host_done;
  logic        r_err;
  logic [6:0]  r_wr_cnt;
  logic [15:0] r_chk;

  logic        w_start_ok;
  logic [3:0]  w_entry;
  logic [AW:0] w_ptr_nxt;
  logic        w_tmo;

  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_FINISH || r_state == S_ERROR);
  assign w_entry    = r_script[r_ptr[AW-1:0]];
  assign w_ptr_nxt  = r_ptr + PTR_ONE;
  assign w_tmo      = (r_wdog == TMO_L);

  always_ff @(posedge i_clk) begin
    if (i_ld_en && r_state == S_IDLE) r_script[i_ld_addr] <= i_ld_cmd;
  end

  // Capture memory; a write coinciding with an accepted start is discarded with the counters.
  always_ff @(posedge i_clk) begin
    if (i_iram_valid && !w_start_ok) r_mem[i_iram_a] <= i_iram_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_cnt <= '0;
      r_chk    <= '0;
    end else if (w_start_ok) begin
      r_wr_cnt <= '0;
      r_chk    <= '0;
    end else if (i_iram_valid) begin
      r_chk <= r_chk + {8'd0, i_iram_d};
      if (r_wr_cnt != 7'd127) r_wr_cnt <= r_wr_cnt + 7'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_len       <= '0;
      r_wdog      <= '0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_host_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_start_ok) begin
        r_len  <= i_ld_len;
        r_ptr  <= '0;
        r_wdog <= '0;
        r_err  <= 1'b0;
        if (i_ld_len == '0) begin
          r_state     <= S_FINISH;
          r_host_done <= 1'b1;
        end else begin
          r_state     <= S_WAIT_RDY;
          r_host_done <= 1'b0;
        end
      end else begin
        case (r_state)
          S_WAIT_RDY: begin
            if (!i_busy) begin
              if (w_entry > 4'd11) begin
                // Illegal entry is skipped; skipping the last one ends the script.
                r_err <= 1'b1;
                r_ptr <= w_ptr_nxt;
                if (w_ptr_nxt == r_len) begin
                  r_state     <= S_FINISH;
                  r_host_done <= 1'b1;
                  r_wdog      <= '0;
                end else begin
                  r_wdog <= r_wdog + 8'd1;
                end
              end else begin
                r_cmd       <= w_entry;
                r_cmd_valid <= 1'b1;
                r_state     <= S_ISSUE;
                r_wdog      <= '0;
              end
            end else if (w_tmo) begin
              r_err <= 1'b1;
              r_host_done <= 1'b1;
              r_state <= S_ERROR;
              r_wdog <= '0;
            end else begin
              r_wdog <= r_wdog + 8'd1;
            end
          end
          S_ISSUE: r_state <= S_WAIT_ACK;
          S_WAIT_ACK: begin
            r_wdog <= '0;
            if (!i_busy) begin
              r_err       <= 1'b1;
              r_host_done <= 1'b1;
              r_state     <= S_ERROR;
            end else begin
              r_state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (!i_busy) begin
              r_ptr  <= w_ptr_nxt;
              r_wdog <= '0;
              if (r_cmd == 4'd0) begin
                r_state <= S_WAIT_DONE;
              end else if (w_ptr_nxt == r_len) begin
                r_state     <= S_FINISH;
                r_host_done <= 1'b1;
              end else begin
                r_state <= S_WAIT_RDY;
              end
            end else if (w_tmo) begin
              r_err <= 1'b1;
              r_host_done <= 1'b1;
              r_state <= S_ERROR;
              r_wdog <= '0;
            end else begin
              r_wdog <= r_wdog + 8'd1;
            end
          end
          S_WAIT_DONE: begin
            if (i_done) begin
              r_state     <= S_FINISH;
              r_host_done <= 1'b1;
              r_wdog      <= '0;
            end else if (w_tmo) begin
              r_err <= 1'b1;
              r_host_done <= 1'b1;
              r_state <= S_ERROR;
              r_wdog <= '0;
            end else begin
              r_wdog <= r_wdog + 8'd1;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign o_cmd       = r_cmd;
  assign o_cmd_valid = r_cmd_valid;
  assign o_host_done = r_host_done;
  assign o_err       = r_err;
  assign o_wr_cnt    = r_wr_cnt;
  assign o_chk       = r_chk;
  assign o_rd_data   = r_mem[i_rd_addr];

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: a behavioural LCD controller drives the handshake and IRAM
// writes, a scoreboard queue holds the expected command order, and a monitor pops it.
module tb_lcd_cmd_host;

  logic        clk;
  logic        rstN;
  logic        ldEn;
  logic [3:0]  ldAddr;
  logic [3:0]  ldCmd;
  logic [4:0]  ldLen;
  logic        start;
  logic [3:0]  cmd;
  logic        cmdValid;
  logic        busyReg;
  logic        forceBusy;
  logic        done;
  logic        iramValid;
  logic [5:0]  iramA;
  logic [7:0]  iramD;
  logic [5:0]  rdAddr;
  logic [7:0]  rdData;
  logic [6:0]  wrCnt;
  logic [15:0] chk;
  logic        hostDone;
  logic        err;
  wire         busy = busyReg | forceBusy;

  int checks = 0;
  int errors = 0;

  int expCmdQ[$];
  int expErr;
  int tbScript[16];
  int image[64];
  int expMem[64];
  int totalWrites = 0;
  int totalSum = 0;
  int baseWrites = 0;
  int baseSum = 0;
  int injectReq = 0;
  int injectDone = 0;
  int px = 4;
  int py = 4;
  bit noAck = 0;
  bit longBusy = 0;

  lcd_cmd_host #(.DEPTH(16), .AW(4), .TMO(255)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_ld_en(ldEn), .i_ld_addr(ldAddr), .i_ld_cmd(ldCmd),
    .i_ld_len(ldLen), .i_start(start), .o_cmd(cmd), .o_cmd_valid(cmdValid), .i_busy(busy),
    .i_done(done), .i_iram_valid(iramValid), .i_iram_a(iramA), .i_iram_d(iramD),
    .i_rd_addr(rdAddr), .o_rd_data(rdData), .o_wr_cnt(wrCnt), .o_chk(chk),
    .o_host_done(hostDone), .o_err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Controller-side helpers: every write is mirrored into the expected image and totals.
  task automatic emit(input int a, input int d);
    iramA = 6'(a);
    iramD = 8'(d);
    iramValid = 1'b1;
    expMem[a] = d;
    totalWrites++;
    totalSum += d;
  endtask

  task automatic applyOp(input int c);
    int a0, v0, v1, v2, v3, m;
    a0 = (py - 1) * 8 + px - 1;
    v0 = image[a0]; v1 = image[a0+1]; v2 = image[a0+8]; v3 = image[a0+9];
    case (c)
      1: if (py > 1) py--;
      2: if (py < 7) py++;
      3: if (px > 1) px--;
      4: if (px < 7) px++;
      5: begin m = v0; if (v1 > m) m = v1; if (v2 > m) m = v2; if (v3 > m) m = v3;
               v0 = m; v1 = m; v2 = m; v3 = m; end
      6: begin m = v0; if (v1 < m) m = v1; if (v2 < m) m = v2; if (v3 < m) m = v3;
               v0 = m; v1 = m; v2 = m; v3 = m; end
      7: begin m = (v0 + v1 + v2 + v3) / 4; v0 = m; v1 = m; v2 = m; v3 = m; end
      8: begin m = v0; v0 = v1; v1 = v3; v3 = v2; v2 = m; end
      9: begin m = v0; v0 = v2; v2 = v3; v3 = v1; v1 = m; end
      10: begin m = v0; v0 = v2; v2 = m; m = v1; v1 = v3; v3 = m; end
      11: begin m = v0; v0 = v1; v1 = m; m = v2; v2 = v3; v3 = m; end
      default: ;
    endcase
    if (c >= 5) begin
      image[a0] = v0; image[a0+1] = v1; image[a0+8] = v2; image[a0+9] = v3;
    end
  endtask

  // Behavioural LCD controller: raises busy the cycle after it sees cmd_valid,
  // streams 64 pixels for a write-out and then holds done until the next command.
  initial begin
    bit pending;
    int pendCmd;
    int busyLeft;
    int woIdx;
    bit doneNext;
    pending = 0; pendCmd = 0; busyLeft = 0; woIdx = -1; doneNext = 0;
    for (int i = 0; i < 64; i++) image[i] = i;
    busyReg = 0; done = 0; iramValid = 0; iramA = 0; iramD = 0;
    forever begin
      @(posedge clk);
      #1;
      iramValid = 1'b0;
      if (doneNext) begin done = 1'b1; doneNext = 0; end
      if (woIdx >= 0) begin
        if (woIdx < 64) begin emit(woIdx, image[woIdx]); woIdx++; end
        else begin busyReg = 1'b0; woIdx = -1; doneNext = 1; end
      end else if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) busyReg = 1'b0;
      end else if (pending) begin
        pending = 0;
        busyReg = 1'b1;
        done = 1'b0;
        if (pendCmd == 0) woIdx = 0;
        else begin
          applyOp(pendCmd);
          busyLeft = longBusy ? 20 : int'($urandom_range(1, 4));
        end
      end else if (injectDone < injectReq) begin
        emit(int'($urandom_range(0, 63)), 255);
        injectDone++;
      end
      if (cmdValid && !noAck) begin pending = 1; pendCmd = int'(cmd); end
    end
  end

  // Monitor: every cmd_valid pulse is popped from the scoreboard and checked.
  initial begin
    bit prevValid;
    prevValid = 0;
    forever begin
      @(negedge clk);
      if (cmdValid) begin
        checkOutput("cmdValidWidth", int'(prevValid), 0);
        checkOutput("busyAtValid", int'(busy), 0);
        if (expCmdQ.size() == 0) checkOutput("unexpectedCmd", int'(cmd) + 100, -1);
        else checkOutput("cmdOrder", int'(cmd), expCmdQ.pop_front());
      end
      prevValid = cmdValid;
    end
  end

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    baseWrites = totalWrites;
    baseSum = totalSum;
  endtask

  task automatic startRun(input int len);
    expErr = 0;
    for (int i = 0; i < len; i++) begin
      if (tbScript[i % 16] > 11) expErr = 1;
      else begin
        expCmdQ.push_back(tbScript[i % 16]);
        if (tbScript[i % 16] == 0) break;
      end
    end
    @(negedge clk);
    ldLen = 5'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    baseWrites = totalWrites;
    baseSum = totalSum;
  endtask

  task automatic applyStimulus(input bit doLoad, input int len);
    if (doLoad) begin
      doReset();
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        ldEn = 1'b1; ldAddr = 4'(i); ldCmd = 4'(tbScript[i]);
      end
      @(negedge clk);
      ldEn = 1'b0;
    end
    startRun(len);
  endtask

  task automatic waitHostDone(input int bound, output int cycles);
    cycles = 0;
    while (!hostDone && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    if (!hostDone) checkOutput("hostDoneTimeout", 0, 1);
  endtask

  function automatic int expWrCnt();
    int n;
    n = totalWrites - baseWrites;
    return (n > 127) ? 127 : n;
  endfunction

  task automatic checkEnd(input string tag);
    checkOutput({tag, "HostDone"}, int'(hostDone), 1);
    checkOutput({tag, "Err"}, int'(err), expErr);
    checkOutput({tag, "WrCnt"}, int'(wrCnt), expWrCnt());
    checkOutput({tag, "Chk"}, int'(chk), (totalSum - baseSum) & 16'hFFFF);
    checkOutput({tag, "PendingCmds"}, expCmdQ.size(), 0);
  endtask

  task automatic checkMem(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      rdAddr = 6'(a);
      #1;
      if (int'(rdData) != expMem[a]) bad++;
    end
    checkOutput({tag, "MemMismatches"}, bad, 0);
  endtask

  task automatic waitInject(input int n);
    int c;
    injectReq += n;
    c = 0;
    while (injectDone < injectReq && c < 1000) begin @(negedge clk); c++; end
    if (injectDone < injectReq) checkOutput("injectTimeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int len;
    int r;
    rstN = 1'b0; ldEn = 0; ldAddr = 0; ldCmd = 0; ldLen = 0; start = 0; rdAddr = 0;
    forceBusy = 0;
    for (int i = 0; i < 16; i++) tbScript[i] = 1;
    repeat (3) @(negedge clk);
    checkOutput("rstCmd", int'(cmd), 0);
    checkOutput("rstCmdValid", int'(cmdValid), 0);
    checkOutput("rstHostDone", int'(hostDone), 0);
    checkOutput("rstErr", int'(err), 0);
    checkOutput("rstWrCnt", int'(wrCnt), 0);
    checkOutput("rstChk", int'(chk), 0);
    rstN = 1'b1;

    $display("[TB] write-out script");
    tbScript[0] = 0;
    applyStimulus(1, 1);
    waitHostDone(500, cyc);
    checkEnd("t1");
    checkOutput("t1WrCnt64", int'(wrCnt), 64);
    checkOutput("t1Chk2016", int'(chk), 2016);
    checkMem("t1");

    $display("[TB] shift/max script");
    tbScript[0] = 1; tbScript[1] = 3; tbScript[2] = 5; tbScript[3] = 0;
    applyStimulus(1, 4);
    waitHostDone(800, cyc);
    checkEnd("t2");
    rdAddr = 6'd27; #1;
    checkOutput("t2Rd27", int'(rdData), 27);
    rdAddr = 6'd18; #1;
    checkOutput("t2Rd18", int'(rdData), 27);
    checkOutput("t2Chk2034", int'(chk), 2034);

    $display("[TB] busy stuck high");
    tbScript[0] = 1;
    forceBusy = 1'b1;
    applyStimulus(1, 1);
    expCmdQ.delete();
    expErr = 1;
    waitHostDone(300, cyc);
    checkEnd("t3");
    checkOutput("t3WdogLatency", int'(cyc >= 250 && cyc <= 260), 1);
    forceBusy = 1'b0;

    $display("[TB] illegal entry skipped");
    tbScript[0] = 12; tbScript[1] = 2;
    applyStimulus(1, 2);
    waitHostDone(100, cyc);
    checkEnd("t4");
    // Load in FINISH must be ignored; the restart replays the held script.
    @(negedge clk);
    ldEn = 1'b1; ldAddr = 4'd1; ldCmd = 4'd7;
    @(negedge clk);
    ldEn = 1'b0;
    applyStimulus(0, 2);
    waitHostDone(100, cyc);
    checkEnd("t4Replay");

    $display("[TB] controller never acknowledges");
    tbScript[0] = 4;
    noAck = 1'b1;
    applyStimulus(1, 1);
    cyc = 0;
    while (!cmdValid && cyc < 20) begin @(negedge clk); cyc++; end
    checkOutput("t5SawValid", int'(cmdValid), 1);
    @(negedge clk);
    checkOutput("t5ErrOnAckCycle", int'(err), 0);
    @(negedge clk);
    checkOutput("t5ErrAfterAck", int'(err), 1);
    expErr = 1;
    checkEnd("t5");
    noAck = 1'b0;

    $display("[TB] reset during WAIT_IDLE");
    tbScript[0] = 1; tbScript[1] = 2; tbScript[2] = 3;
    longBusy = 1'b1;
    applyStimulus(1, 3);
    cyc = 0;
    while (!busy && cyc < 30) begin @(negedge clk); cyc++; end
    checkOutput("t6SawBusy", int'(busy), 1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("t6RstCmd", int'(cmd), 0);
    checkOutput("t6RstHostDone", int'(hostDone), 0);
    checkOutput("t6RstErr", int'(err), 0);
    checkOutput("t6RstCmdValid", int'(cmdValid), 0);
    @(negedge clk);
    rstN = 1'b1;
    longBusy = 1'b0;
    expCmdQ.delete();
    baseWrites = totalWrites;
    baseSum = totalSum;
    applyStimulus(0, 3);
    waitHostDone(300, cyc);
    checkEnd("t6");

    $display("[TB] zero length and counter saturation");
    doReset();
    tbScript[0] = 0;
    startRun(0);
    @(negedge clk);
    checkEnd("len0");
    waitInject(127);
    checkOutput("sat127", int'(wrCnt), 127);
    checkOutput("sat127Chk", int'(chk), (totalSum - baseSum) & 16'hFFFF);
    waitInject(133);
    checkOutput("satHold", int'(wrCnt), 127);
    checkOutput("chkWrap", int'(chk), 764);

    $display("[TB] randomized scripts");
    for (int it = 0; it < 12; it++) begin
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 10) tbScript[i] = int'($urandom_range(12, 15));
        else if (r < 25) tbScript[i] = 0;
        else tbScript[i] = int'($urandom_range(1, 11));
      end
      applyStimulus(1, len);
      waitHostDone(2000, cyc);
      checkEnd("rand");
      checkMem("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
